// File: rtl/cpu_params.sv
// Core-wide sizing constants shared by the out-of-order integer core.
// ROB_DEPTH must be a power of two. ROB pointers carry one wrap bit above the
// index bits, which lets full and empty be told apart.
package cpu_params;

  localparam int ROB_DEPTH = 32;
  localparam int CDB_WIDTH = 2;
  localparam int ROB_IDX   = $clog2(ROB_DEPTH);
  localparam int ROB_PTR_W = ROB_IDX + 1;
  localparam int ARF_IDX   = 5;
  localparam int PRF_IDX   = 6;

endpackage

// File: rtl/rob_types.sv
// Types used by the reorder buffer.
//   cdb_rob_t   : one completion broadcast lane {rob_id, valid}
//   rob_entry_t : one buffer slot {valid, ready, rd_arch, rd_phy}
package rob_types;

  import cpu_params::*;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic               valid;
  } cdb_rob_t;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [ARF_IDX-1:0] rd_arch;
    logic [PRF_IDX-1:0] rd_phy;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer.
// Entries are allocated in program order at dispatch and marked complete by CDB
// broadcasts. At most one completed head entry retires per cycle, in order.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   dispatch_valid      rename offers a uop
//   dispatch_ready      a slot is free; this looks at current state only
//   dispatch_rd_arch    architectural destination of the offered uop
//   dispatch_rd_phy     physical destination of the offered uop
//   dispatch_rob_id     tail index the uop receives on handshake
//   cdb                 completion broadcasts, one {rob_id, valid} per lane
//   commit_valid        head entry retires this cycle
//   commit_rob_id       head index
//   commit_rd_arch      retiring architectural destination
//   commit_rd_phy       retiring physical destination
//   commit_order        RVFI order number of the retiring instruction
// All commit_* outputs depend only on registered state.
module rob
  import rob_types::*;
#(
  parameter int ROB_DEPTH = cpu_params::ROB_DEPTH,
  parameter int CDB_WIDTH = cpu_params::CDB_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dispatch_valid,
  output logic                             dispatch_ready,
  input  logic [cpu_params::ARF_IDX-1:0]   dispatch_rd_arch,
  input  logic [cpu_params::PRF_IDX-1:0]   dispatch_rd_phy,
  output logic [cpu_params::ROB_IDX-1:0]   dispatch_rob_id,
  input  cdb_rob_t [CDB_WIDTH-1:0]         cdb,
  output logic                             commit_valid,
  output logic [cpu_params::ROB_IDX-1:0]   commit_rob_id,
  output logic [cpu_params::ARF_IDX-1:0]   commit_rd_arch,
  output logic [cpu_params::PRF_IDX-1:0]   commit_rd_phy,
  output logic [63:0]                      commit_order
);

  localparam int IDX_W = cpu_params::ROB_IDX;
  localparam int PTR_W = cpu_params::ROB_PTR_W;

  logic [PTR_W-1:0] head_ptr_r;
  logic [PTR_W-1:0] tail_ptr_r;
  logic [63:0]      order_r;
  rob_entry_t       entries_r [ROB_DEPTH];

  logic [IDX_W-1:0] head_idx_s;
  logic [IDX_W-1:0] tail_idx_s;
  logic             full_s;
  logic             dispatch_fire_s;
  logic             commit_fire_s;
  rob_entry_t       head_entry_s;

  // Pointer decode, full detection and the two handshake conditions.
  always_comb begin
    head_idx_s   = head_ptr_r[IDX_W-1:0];
    tail_idx_s   = tail_ptr_r[IDX_W-1:0];
    head_entry_s = entries_r[head_idx_s];
    // Same slot index with differing wrap bits means the tail lapped the head.
    if ((head_idx_s == tail_idx_s) && (head_ptr_r[PTR_W-1] != tail_ptr_r[PTR_W-1])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    dispatch_fire_s = dispatch_valid && !full_s;
    commit_fire_s   = head_entry_s.valid && head_entry_s.ready;
  end

  // Output drive; a commit this cycle does not free a slot until the next one.
  always_comb begin
    dispatch_ready  = !full_s;
    dispatch_rob_id = tail_idx_s;
    commit_valid    = commit_fire_s;
    commit_rob_id   = head_idx_s;
    commit_rd_arch  = head_entry_s.rd_arch;
    commit_rd_phy   = head_entry_s.rd_phy;
    commit_order    = order_r;
  end

  // Entry array, pointers and order counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_r <= '0;
      tail_ptr_r <= '0;
      order_r    <= 64'd0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (dispatch_fire_s) begin
        entries_r[tail_idx_s] <= '{valid: 1'b1, ready: 1'b0,
                                   rd_arch: dispatch_rd_arch, rd_phy: dispatch_rd_phy};
        tail_ptr_r <= tail_ptr_r + PTR_W'(1'b1);
      end
      // Broadcasts to empty slots are dropped; duplicate lanes are harmless.
      for (int l = 0; l < CDB_WIDTH; l++) begin
        if (cdb[l].valid && entries_r[cdb[l].rob_id].valid) begin
          entries_r[cdb[l].rob_id].ready <= 1'b1;
        end
      end
      // Placed after the CDB loop so a retiring slot always ends up clear.
      if (commit_fire_s) begin
        entries_r[head_idx_s].valid <= 1'b0;
        entries_r[head_idx_s].ready <= 1'b0;
        head_ptr_r <= head_ptr_r + PTR_W'(1'b1);
        order_r    <= order_r + 64'd1;
      end
    end
  end

endmodule
